// File: rtl/led_pkg.sv
// Shared definitions for the LED shift driver: FSM state encoding and register addresses.
package led_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StShiftLo = 2'd1,
    StShiftHi = 2'd2,
    StLatch   = 2'd3
  } led_state_e;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;

  localparam int unsigned DivW = 8;

endpackage

// File: rtl/led_shift_driver_if.sv
// Avalon-MM slave bus bundle for the LED shift driver (write/read strobes, no waitrequest).
interface led_shift_driver_if;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;

  modport master (
    output address,
    output write,
    output writedata,
    output read,
    input  readdata
  );

  modport slave (
    input  address,
    input  write,
    input  writedata,
    input  read,
    output readdata
  );
endinterface

// File: rtl/led_clk_div.sv
// Half-period timer: load restarts a CLK_DIV-cycle interval, tick marks its last cycle.
module led_clk_div
  import led_pkg::*;
#(
  parameter int unsigned ClkDiv = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  output logic tick_o
);

  localparam logic [DivW-1:0] Reload = DivW'(ClkDiv - 1);

  logic [DivW-1:0] cnt_q, cnt_d;

  // Count down and park at zero; never wraps past the reload value.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = Reload;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/led_shift_driver.sv
// Serialises one DATA_W-bit word MSB first to an LED driver chain, then pulses latch.
module led_shift_driver
  import led_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                      csi_clk,
  input  logic                      rsi_reset_n,
  led_shift_driver_if.slave         avs,
  output logic                      led_sdi,
  output logic                      led_sclk,
  output logic                      led_latch,
  output logic                      led_oe_n
);

  localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  led_state_e        state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]   bitcnt_q, bitcnt_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic              oe_n_q, oe_n_d;
  logic              sdi_q, sdi_d;
  logic              sclk_q, sclk_d;
  logic              latch_q, latch_d;
  logic [31:0]       rdata_q, rdata_d;

  logic div_load;
  logic div_tick;
  logic data_wr;
  logic ctrl_wr;
  logic unused_wdata;

  assign data_wr      = avs.write && (avs.address == ADDR_DATA);
  assign ctrl_wr      = avs.write && (avs.address == ADDR_CTRL);
  assign unused_wdata = ^avs.writedata;

  led_clk_div #(
    .ClkDiv (CLK_DIV)
  ) u_clk_div (
    .clk_i  (csi_clk),
    .rst_ni (rsi_reset_n),
    .load_i (div_load),
    .tick_o (div_tick)
  );

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    div_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (data_wr) begin
          shreg_d  = avs.writedata[DATA_W-1:0];
          bitcnt_d = CntW'(DATA_W - 1);
          state_d  = StShiftLo;
          div_load = 1'b1;
        end
      end
      StShiftLo: begin
        if (div_tick) begin
          state_d  = StShiftHi;
          div_load = 1'b1;
        end
      end
      StShiftHi: begin
        if (div_tick) begin
          div_load = 1'b1;
          if (bitcnt_q == '0) begin
            state_d = StLatch;
          end else begin
            shreg_d  = shreg_q << 1;
            bitcnt_d = bitcnt_q - 1'b1;
            state_d  = StShiftLo;
          end
        end
      end
      StLatch: begin
        if (div_tick) begin
          state_d  = StIdle;
          div_load = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are computed from next state so the pins flip on the same edge as the FSM.
  always_comb begin
    busy_d  = (state_d != StIdle);
    sclk_d  = (state_d == StShiftHi);
    latch_d = (state_d == StLatch);
    sdi_d   = ((state_d == StShiftLo) || (state_d == StShiftHi)) ? shreg_d[DATA_W-1] : 1'b0;

    overrun_d = overrun_q;
    if (ctrl_wr && avs.writedata[1]) begin
      overrun_d = 1'b0;
    end
    if (data_wr && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end

    oe_n_d = ctrl_wr ? ~avs.writedata[0] : oe_n_q;

    rdata_d = rdata_q;
    if (avs.read) begin
      rdata_d = (avs.address == ADDR_STATUS) ? {30'b0, overrun_q, busy_q} : 32'b0;
    end
  end

  always_ff @(posedge csi_clk) begin
    if (!rsi_reset_n) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      oe_n_q    <= 1'b1;
      sdi_q     <= 1'b0;
      sclk_q    <= 1'b0;
      latch_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bitcnt_q  <= bitcnt_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      oe_n_q    <= oe_n_d;
      sdi_q     <= sdi_d;
      sclk_q    <= sclk_d;
      latch_q   <= latch_d;
      rdata_q   <= rdata_d;
    end
  end

  assign led_sdi      = sdi_q;
  assign led_sclk     = sclk_q;
  assign led_latch    = latch_q;
  assign led_oe_n     = oe_n_q;
  assign avs.readdata = rdata_q;

endmodule

// File: tb/tb_led_shift_driver.sv
// Directed bench: instance A (CLK_DIV=4) for the main scenarios, instance B (CLK_DIV=1) for speed.
module tb_led_shift_driver;

  logic csi_clk = 1'b0;
  initial forever #5 csi_clk = ~csi_clk;

  logic rst_a_n, rst_b_n;
  logic sdi_a, sclk_a, latch_a, oe_n_a;
  logic sdi_b, sclk_b, latch_b, oe_n_b;

  led_shift_driver_if a_if ();
  led_shift_driver_if b_if ();

  led_shift_driver #(.DATA_W(16), .CLK_DIV(4)) u_dut_a (
    .csi_clk     (csi_clk),
    .rsi_reset_n (rst_a_n),
    .avs         (a_if),
    .led_sdi     (sdi_a),
    .led_sclk    (sclk_a),
    .led_latch   (latch_a),
    .led_oe_n    (oe_n_a)
  );

  led_shift_driver #(.DATA_W(16), .CLK_DIV(1)) u_dut_b (
    .csi_clk     (csi_clk),
    .rsi_reset_n (rst_b_n),
    .avs         (b_if),
    .led_sdi     (sdi_b),
    .led_sclk    (sclk_b),
    .led_latch   (latch_b),
    .led_oe_n    (oe_n_b)
  );

  // Line monitors: capture led_sdi on every led_sclk rising edge as the LED driver would.
  logic        sclk_a_prev = 1'b0, latch_a_prev = 1'b0, sclk_b_prev = 1'b0;
  logic [15:0] cap_a = '0, cap_b = '0;
  int          rises_a = 0, latch_cyc_a = 0, latch_pulse_a = 0;
  int          rises_b = 0, toggles_b = 0;

  always @(negedge csi_clk) begin
    sclk_a_prev  <= sclk_a;
    latch_a_prev <= latch_a;
    if (sclk_a && !sclk_a_prev) begin
      cap_a   <= {cap_a[14:0], sdi_a};
      rises_a <= rises_a + 1;
    end
    if (latch_a) latch_cyc_a <= latch_cyc_a + 1;
    if (latch_a && !latch_a_prev) latch_pulse_a <= latch_pulse_a + 1;
    sclk_b_prev <= sclk_b;
    if (sclk_b != sclk_b_prev) toggles_b <= toggles_b + 1;
    if (sclk_b && !sclk_b_prev) begin
      cap_b   <= {cap_b[14:0], sdi_b};
      rises_b <= rises_b + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge csi_clk);
  endtask

  task automatic bus_write(input bit sel, input logic [1:0] a, input logic [31:0] d);
    @(negedge csi_clk);
    if (sel) begin
      b_if.address = a; b_if.writedata = d; b_if.write = 1'b1;
    end else begin
      a_if.address = a; a_if.writedata = d; a_if.write = 1'b1;
    end
    @(negedge csi_clk);
    a_if.write = 1'b0; a_if.address = 2'd0;
    b_if.write = 1'b0; b_if.address = 2'd0;
  endtask

  task automatic bus_read(input bit sel, input logic [1:0] a, output logic [31:0] v);
    @(negedge csi_clk);
    if (sel) begin
      b_if.address = a; b_if.read = 1'b1;
    end else begin
      a_if.address = a; a_if.read = 1'b1;
    end
    @(negedge csi_clk);
    v = sel ? b_if.readdata : a_if.readdata;
    a_if.read = 1'b0; a_if.address = 2'd0;
    b_if.read = 1'b0; b_if.address = 2'd0;
  endtask

  // Poll STATUS every cycle from the cycle after a write; counts cycles busy was high.
  task automatic poll_busy(input bit sel, output int n);
    logic [31:0] v;
    n = 0;
    if (sel) begin
      b_if.address = 2'd1; b_if.read = 1'b1;
    end else begin
      a_if.address = 2'd1; a_if.read = 1'b1;
    end
    for (int i = 0; i < 400; i++) begin
      @(negedge csi_clk);
      v = sel ? b_if.readdata : a_if.readdata;
      if (v[0]) n++;
      else break;
    end
    a_if.read = 1'b0; a_if.address = 2'd0;
    b_if.read = 1'b0; b_if.address = 2'd0;
  endtask

  initial begin
    logic [31:0] v;
    int n, r0, p0, l0, t0;

    a_if.address = '0; a_if.write = 1'b0; a_if.writedata = '0; a_if.read = 1'b0;
    b_if.address = '0; b_if.write = 1'b0; b_if.writedata = '0; b_if.read = 1'b0;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    wait_cyc(3);
    check("reset_sdi", {31'b0, sdi_a}, 32'd0);
    check("reset_sclk", {31'b0, sclk_a}, 32'd0);
    check("reset_latch", {31'b0, latch_a}, 32'd0);
    check("reset_oe_n", {31'b0, oe_n_a}, 32'd1);
    check("reset_readdata", a_if.readdata, 32'd0);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    wait_cyc(2);

    // Single transfer of 0xA5C3.
    r0 = rises_a; l0 = latch_cyc_a; p0 = latch_pulse_a;
    bus_write(1'b0, 2'd0, 32'h0000_A5C3);
    poll_busy(1'b0, n);
    check("a5c3_busy_cycles", n, 32'd132);
    wait_cyc(1);
    check("a5c3_word", {16'b0, cap_a}, 32'h0000_A5C3);
    check("a5c3_rises", rises_a - r0, 32'd16);
    check("a5c3_latch_cycles", latch_cyc_a - l0, 32'd4);
    check("a5c3_latch_pulses", latch_pulse_a - p0, 32'd1);
    bus_read(1'b0, 2'd1, v);
    check("a5c3_status_idle", v, 32'd0);

    // Overrun: second DATA write during a transfer is dropped.
    r0 = rises_a; p0 = latch_pulse_a;
    bus_write(1'b0, 2'd0, 32'h0000_1234);
    wait_cyc(9);
    bus_write(1'b0, 2'd0, 32'h0000_FFFF);
    bus_read(1'b0, 2'd1, v);
    check("overrun_status_busy", v, 32'd3);
    poll_busy(1'b0, n);
    wait_cyc(1);
    bus_read(1'b0, 2'd1, v);
    check("overrun_status_after", v, 32'd2);
    check("overrun_word", {16'b0, cap_a}, 32'h0000_1234);
    check("overrun_rises", rises_a - r0, 32'd16);
    check("overrun_latch_pulses", latch_pulse_a - p0, 32'd1);
    bus_write(1'b0, 2'd2, 32'h0000_0002);
    bus_read(1'b0, 2'd1, v);
    check("overrun_cleared", v, 32'd0);

    // Output enable, including a change in the middle of a transfer.
    bus_write(1'b0, 2'd2, 32'h0000_0001);
    check("oe_n_enable", {31'b0, oe_n_a}, 32'd0);
    r0 = rises_a;
    bus_write(1'b0, 2'd0, 32'h0000_5AF0);
    wait_cyc(20);
    bus_write(1'b0, 2'd2, 32'h0000_0000);
    check("oe_n_disable_mid", {31'b0, oe_n_a}, 32'd1);
    poll_busy(1'b0, n);
    wait_cyc(1);
    check("oe_mid_word", {16'b0, cap_a}, 32'h0000_5AF0);
    check("oe_mid_rises", rises_a - r0, 32'd16);
    bus_read(1'b0, 2'd1, v);
    check("oe_mid_status", v, 32'd0);

    // Reserved and non-status addresses.
    bus_write(1'b0, 2'd3, 32'hFFFF_FFFF);
    check("addr3_oe_n", {31'b0, oe_n_a}, 32'd1);
    bus_read(1'b0, 2'd3, v);
    check("addr3_read", v, 32'd0);
    bus_read(1'b0, 2'd0, v);
    check("addr0_read", v, 32'd0);

    // Reset in the middle of a transfer: no latch, everything back to reset values.
    bus_write(1'b0, 2'd2, 32'h0000_0001);
    p0 = latch_pulse_a;
    bus_write(1'b0, 2'd0, 32'h0000_FFFF);
    wait_cyc(52);
    check("midreset_pre_sclk", {31'b0, sclk_a}, 32'd1);
    check("midreset_pre_sdi", {31'b0, sdi_a}, 32'd1);
    a_if.address = 2'd1; a_if.read = 1'b1;
    rst_a_n = 1'b0;
    @(negedge csi_clk);
    check("midreset_sdi", {31'b0, sdi_a}, 32'd0);
    check("midreset_sclk", {31'b0, sclk_a}, 32'd0);
    check("midreset_latch", {31'b0, latch_a}, 32'd0);
    check("midreset_oe_n", {31'b0, oe_n_a}, 32'd1);
    check("midreset_readdata", a_if.readdata, 32'd0);
    rst_a_n = 1'b1;
    a_if.read = 1'b0; a_if.address = 2'd0;
    wait_cyc(200);
    check("midreset_no_latch", latch_pulse_a - p0, 32'd0);
    bus_read(1'b0, 2'd1, v);
    check("midreset_status", v, 32'd0);

    // CLK_DIV = 1 instance.
    r0 = rises_b; t0 = toggles_b;
    bus_write(1'b1, 2'd0, 32'h0000_FFFF);
    poll_busy(1'b1, n);
    check("div1_busy_cycles", n, 32'd33);
    wait_cyc(1);
    check("div1_word", {16'b0, cap_b}, 32'h0000_FFFF);
    check("div1_rises", rises_b - r0, 32'd16);
    check("div1_toggles", toggles_b - t0, 32'd32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_shift_driver.md
LED_SHIFT_DRIVER -- requirements
Module: led_shift_driver

Interface
REQ-001 Parameter DATA_W, default 16, bit count of one LED column word shifted per transfer.
REQ-002 Parameter CLK_DIV, default 4, csi_clk cycles per led_sclk half-period (legal range 1..255).
REQ-003 Port csi_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rsi_reset_n  input  1  reset, synchronous, active-low.
REQ-005 Port avs_address  input  2  Avalon-MM word address.
REQ-006 Port avs_write  input  1  write strobe, single-cycle, no waitrequest.
REQ-007 Port avs_writedata  input  32  write data.
REQ-008 Port avs_read  input  1  read strobe.
REQ-009 Port avs_readdata  output  32  read data, registered, valid the cycle after avs_read.
REQ-010 Port led_sdi  output  1  serial data to LED driver chain, MSB first.
REQ-011 Port led_sclk  output  1  serial clock; driver samples led_sdi on its rising edge.
REQ-012 Port led_latch  output  1  latch pulse, active-high, transfers shifted word to driver outputs.
REQ-013 Port led_oe_n  output  1  driver output enable, active-low.

Function
REQ-014 Register map SHALL be: addr 0 write DATA[DATA_W-1:0]; addr 1 read STATUS {bit1 overrun, bit0 busy}; addr 2 write CTRL {bit0 enable, bit1 clear_overrun}; addr 3 reserved (writes ignored, reads 0).
REQ-015 FSM SHALL have states IDLE, SHIFT_LO, SHIFT_HI, LATCH.
REQ-016 In IDLE, write to addr 0 SHALL load the shift register and bit counter (DATA_W-1) and enter SHIFT_LO the next cycle; busy SHALL be 1 from that cycle.
REQ-017 SHIFT_LO: led_sclk=0, led_sdi=current MSB, held CLK_DIV cycles, then SHIFT_HI.
REQ-018 SHIFT_HI: led_sclk=1 for CLK_DIV cycles; then, if counter=0 go to LATCH, else shift left by one, decrement counter, go to SHIFT_LO.
REQ-019 LATCH: led_latch=1, led_sclk=0 for CLK_DIV cycles, then IDLE; busy SHALL drop to 0 on IDLE entry.
REQ-020 Busy duration per transfer SHALL be exactly (2*DATA_W+1)*CLK_DIV cycles.
REQ-021 Write to addr 0 while busy SHALL be discarded, in-flight transfer unaffected, and STATUS.overrun set (sticky).
REQ-022 Write to addr 2 with bit1=1 SHALL clear overrun; if a discarded DATA write coincides in the same cycle, set wins (impossible on one bus, documented for completeness).
REQ-023 led_oe_n SHALL equal ~CTRL.enable, registered, changing one cycle after the addr 2 write, independent of FSM state.
REQ-024 Divider counter SHALL be CLK_DIV-wide enough (8 bits), reload on every state transition, no wrap beyond CLK_DIV-1.
REQ-025 led_sdi SHALL be 0 and led_sclk, led_latch 0 in IDLE.
REQ-026 avs_readdata SHALL return STATUS on addr 1, 0 on other addresses; upper bits 0.

Reset
REQ-027 On rsi_reset_n=0 at a clock edge: state IDLE, shift register 0, counters 0, busy 0, overrun 0, enable 0.
REQ-028 Reset values of outputs: led_sdi 0, led_sclk 0, led_latch 0, led_oe_n 1, avs_readdata 0.
REQ-029 Reset mid-transfer SHALL abort without issuing led_latch; the partially shifted word is never latched.

Structure
REQ-030 State encoding enum and register address constants (ADDR_DATA, ADDR_STATUS, ADDR_CTRL) SHALL live in shared package led_pkg.
REQ-031 The CLK_DIV half-period timer SHALL be a sub-module led_clk_div (inputs load, outputs tick).
REQ-032 All outputs SHALL be driven directly from flops (no combinational output path).

Verification
REQ-033 DATA_W=16, CLK_DIV=4, write 0xA5C3 to addr 0 -> 16 sclk rising edges sample bits 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; one 4-cycle led_latch; busy high 132 cycles.
REQ-034 Write 0x1234 then 0xFFFF 10 cycles later -> only 0x1234 shifted; STATUS read returns 0x3 during transfer, 0x2 after.
REQ-035 After overrun, write 0x2 to addr 2 -> STATUS reads 0x0.
REQ-036 Write 0x1 to addr 2 -> led_oe_n falls next cycle; write 0x0 -> rises next cycle, also mid-transfer without disturbing sclk.
REQ-037 Assert rsi_reset_n=0 at cycle 50 of a transfer -> next edge all outputs at reset values, no latch pulse, STATUS 0x0.
REQ-038 CLK_DIV=1, write 0xFFFF -> sclk toggles every cycle, busy exactly 33 cycles.
